// File: rtl/fan_pkg.sv
// Shared fan-control definitions: speed level encodings, default duty
// targets and timing defaults used by the fan timer, LED driver and PWM.
package fan_pkg;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_LOW  = 2'd1,
    LVL_MID  = 2'd2,
    LVL_HIGH = 2'd3
  } fan_level_e;

  localparam int         CLK_PER_MS_DEF = 100_000;
  localparam int         RAMP_MS_DEF    = 4;
  localparam logic [7:0] DUTY_LOW_DEF   = 8'd64;
  localparam logic [7:0] DUTY_MID_DEF   = 8'd128;
  localparam logic [7:0] DUTY_HIGH_DEF  = 8'd255;

  // Level sequencing: timeout always forces OFF and masks the button,
  // otherwise each button pulse advances OFF->LOW->MID->HIGH->OFF.
  function automatic fan_level_e fan_next_level(fan_level_e lvl, logic btn, logic timeout);
    fan_level_e nxt;
    nxt = lvl;
    if (timeout) begin
      nxt = LVL_OFF;
    end else if (btn) begin
      case (lvl)
        LVL_OFF:  nxt = LVL_LOW;
        LVL_LOW:  nxt = LVL_MID;
        LVL_MID:  nxt = LVL_HIGH;
        default:  nxt = LVL_OFF;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fan_duty_ctrl_if.sv
// Control/status bundle between the fan duty controller and its user:
// button and timeout in, duty command, level and ramp status out.
interface fan_duty_ctrl_if;
  logic       btn;
  logic       timeout;
  logic [7:0] duty;
  logic [1:0] level;
  logic       ramping;

  modport master (output btn, timeout, input duty, level, ramping);
  modport slave  (input btn, timeout, output duty, level, ramping);
endinterface

// File: rtl/clock_div.sv
// Free-running divider producing a one-cycle strobe every CLK_PER_MS clocks.
module clock_div #(
  parameter int CLK_PER_MS = 100_000
) (
  input  logic clk,
  input  logic reset_p,
  output logic div_edge_o
);

  localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  logic [CW-1:0] cnt_q;

  assign div_edge_o = (cnt_q == CW'(CLK_PER_MS - 1));

  // Count 0..CLK_PER_MS-1 and wrap on the strobe cycle.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      cnt_q <= '0;
    end else if (div_edge_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fan_duty_ctrl.sv
// Fan speed selector with soft-start duty ramp.
//
//   state    | meaning
//   LVL_OFF  | fan off, duty forced to 0
//   LVL_LOW  | ramp toward / hold DUTY_LOW
//   LVL_MID  | ramp toward / hold DUTY_MID
//   LVL_HIGH | ramp toward / hold DUTY_HIGH
module fan_duty_ctrl
  import fan_pkg::*;
#(
  parameter int         CLK_PER_MS = CLK_PER_MS_DEF,
  parameter int         RAMP_MS    = RAMP_MS_DEF,
  parameter logic [7:0] DUTY_LOW   = DUTY_LOW_DEF,
  parameter logic [7:0] DUTY_MID   = DUTY_MID_DEF,
  parameter logic [7:0] DUTY_HIGH  = DUTY_HIGH_DEF
) (
  input  logic            clk,
  input  logic            reset_p,
  fan_duty_ctrl_if.slave  bus
);

  localparam int SW = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;

  function automatic logic [7:0] target_of(fan_level_e lvl);
    case (lvl)
      LVL_LOW:  return DUTY_LOW;
      LVL_MID:  return DUTY_MID;
      LVL_HIGH: return DUTY_HIGH;
      default:  return 8'd0;
    endcase
  endfunction

  logic          div_edge;
  logic          step_stb;
  logic [SW-1:0] step_cnt_q;
  fan_level_e    level_q;
  fan_level_e    level_d;
  logic [7:0]    duty_q;
  logic [7:0]    tgt_d;

  clock_div #(.CLK_PER_MS(CLK_PER_MS)) u_clock_div (
    .clk        (clk),
    .reset_p    (reset_p),
    .div_edge_o (div_edge)
  );

  assign step_stb = div_edge && (step_cnt_q == SW'(RAMP_MS - 1));

  // ms-tick counter; free-running so a level change never restarts the step cadence.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      step_cnt_q <= '0;
    end else if (div_edge) begin
      if (step_cnt_q == SW'(RAMP_MS - 1)) begin
        step_cnt_q <= '0;
      end else begin
        step_cnt_q <= step_cnt_q + 1'b1;
      end
    end
  end

  // Steps are taken toward the target of the level being entered this cycle,
  // so a press coinciding with a strobe already ramps in the new direction.
  assign level_d = fan_next_level(level_q, bus.btn, bus.timeout);
  assign tgt_d   = target_of(level_d);

  // Level FSM and duty register; OFF drops duty at once, other levels step 1 LSB per strobe.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      level_q <= LVL_OFF;
      duty_q  <= 8'd0;
    end else begin
      level_q <= level_d;
      if (level_d == LVL_OFF) begin
        duty_q <= 8'd0;
      end else if (step_stb && (duty_q < tgt_d)) begin
        duty_q <= duty_q + 8'd1;
      end else if (step_stb && (duty_q > tgt_d)) begin
        duty_q <= duty_q - 8'd1;
      end
    end
  end

  assign bus.duty    = duty_q;
  assign bus.level   = level_q;
  assign bus.ramping = (duty_q != target_of(level_q));

endmodule

// File: tb/tb_fan_duty_ctrl.sv
// Bench for fan_duty_ctrl: short vector table, directed ramp/timeout/reset
// sequences and random traffic, all checked every cycle against a cycle-count
// based reference model.
module tb_fan_duty_ctrl;

  localparam int CPM      = 10;
  localparam int RMS      = 2;
  localparam int STEP_PER = CPM * RMS;

  logic clk = 1'b0;
  logic reset_p;

  fan_duty_ctrl_if bus ();

  fan_duty_ctrl #(
    .CLK_PER_MS (CPM),
    .RAMP_MS    (RMS)
  ) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: clocks since last reset, selected level, duty.
  int m_n     = 0;
  int m_level = 0;
  int m_duty  = 0;

  typedef struct {
    logic b;
    logic t;
    logic r;
    int   lvl;
    int   duty;
    int   ramp;
  } vec_t;

  vec_t vecs[12];

  function automatic int tgt(int l);
    case (l)
      1:       return 64;
      2:       return 128;
      3:       return 255;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance the model by the rules, compare after the edge.
  task automatic tick(input logic b, input logic t, input logic r);
    bit step;
    bus.btn     = b;
    bus.timeout = t;
    reset_p     = r;
    @(posedge clk);
    if (r) begin
      m_n = 0; m_level = 0; m_duty = 0;
    end else begin
      step = ((m_n % STEP_PER) == STEP_PER - 1);
      if (t) begin
        m_level = 0; m_duty = 0;
      end else begin
        if (b) m_level = (m_level + 1) % 4;
        if (m_level == 0)                         m_duty = 0;
        else if (step && m_duty < tgt(m_level))  m_duty = m_duty + 1;
        else if (step && m_duty > tgt(m_level))  m_duty = m_duty - 1;
      end
      m_n++;
    end
    @(negedge clk);
    check("model_duty",    int'(bus.duty),    m_duty);
    check("model_level",   int'(bus.level),   m_level);
    check("model_ramping", int'(bus.ramping), (m_duty != tgt(m_level)) ? 1 : 0);
  endtask

  task automatic wait_duty(input int v, input int budget, input string name);
    int c;
    c = 0;
    while (m_duty != v && c < budget) begin
      tick(1'b0, 1'b0, 1'b0);
      c++;
    end
    check(name, int'(bus.duty), v);
  endtask

  initial begin
    int cnt;
    bus.btn     = 1'b0;
    bus.timeout = 1'b0;
    reset_p     = 1'b1;

    // Reset: 3 cycles, then held for 500 more.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    check("rst_duty",    int'(bus.duty), 0);
    check("rst_level",   int'(bus.level), 0);
    check("rst_ramping", int'(bus.ramping), 0);
    for (int i = 0; i < 500; i++) tick(1'b0, 1'b0, 1'b1);
    check("rst_hold_duty",  int'(bus.duty), 0);
    check("rst_hold_level", int'(bus.level), 0);

    // Vector table: short sequences well before the first step strobe.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1, 0, 1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2, 0, 1};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 0, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1, 0, 1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 2, 0, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3, 0, 1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
    tick(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].b, vecs[i].t, vecs[i].r);
      check($sformatf("vec%0d_level", i),   int'(bus.level),   vecs[i].lvl);
      check($sformatf("vec%0d_duty", i),    int'(bus.duty),    vecs[i].duty);
      check($sformatf("vec%0d_ramping", i), int'(bus.ramping), vecs[i].ramp);
    end

    // Single press and full level cycle.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check("press1_level", int'(bus.level), 1);
    wait_duty(64, 1400, "settle_low");
    check("settle_low_ramping", int'(bus.ramping), 0);
    tick(1'b1, 1'b0, 1'b0);
    check("press2_level", int'(bus.level), 2);
    wait_duty(128, 1400, "settle_mid");
    tick(1'b1, 1'b0, 1'b0);
    check("press3_level", int'(bus.level), 3);
    wait_duty(255, 2700, "settle_high");
    check("settle_high_ramping", int'(bus.ramping), 0);
    tick(1'b1, 1'b0, 1'b0);
    check("press4_level", int'(bus.level), 0);
    check("press4_duty",  int'(bus.duty), 0);

    // Timeout at HIGH, duty 200, with button pulses ignored.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    wait_duty(200, 4200, "reach_200");
    for (int i = 0; i < 5; i++) begin
      tick((i % 2) == 0, 1'b1, 1'b0);
      check("timeout_level", int'(bus.level), 0);
      check("timeout_duty",  int'(bus.duty), 0);
    end
    tick(1'b0, 1'b0, 1'b0);
    check("after_timeout_level", int'(bus.level), 0);

    // Simultaneous btn+timeout at LOW.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("simul_level", int'(bus.level), 0);

    // Reversal: press at duty 100 while ramping to 128.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    wait_duty(100, 2200, "reach_100");
    tick(1'b1, 1'b0, 1'b0);
    check("rev_level", int'(bus.level), 3);
    wait_duty(101, 25, "rev_101");
    wait_duty(102, 25, "rev_102");

    // Reset mid-ramp at duty 37, then step cadence restarts.
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    wait_duty(37, 800, "reach_37");
    tick(1'b0, 1'b0, 1'b1);
    check("midrst_duty",  int'(bus.duty), 0);
    check("midrst_level", int'(bus.level), 0);
    tick(1'b1, 1'b0, 1'b0);
    cnt = 1;
    while (bus.duty == 8'd0 && cnt < 40) begin
      tick(1'b0, 1'b0, 1'b0);
      cnt++;
    end
    check("first_step_latency", cnt, STEP_PER);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 999) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fan_duty_ctrl.md
# fan_duty_ctrl

Fan speed selector and soft-start ramp generator. It turns the debounced speed button into an 8-bit PWM duty command and ramps that duty toward the selected level, one step at a time, to limit inrush current. A timeout from the fan timer forces it to off. It sits directly upstream of the fan timer and the PWM generator: its `duty` feeds both, and it consumes the fan timer's `timeout`.

## Interface
- `CLK_PER_MS`, 100_000, clk cycles per 1 ms tick.
- `RAMP_MS`, 4, ms ticks per 1-LSB duty step (≥1).
- `DUTY_LOW`, 8'd64, target duty for level 1.
- `DUTY_MID`, 8'd128, target duty for level 2.
- `DUTY_HIGH`, 8'd255, target duty for level 3.
- `clk` in 1: system clock; one clock domain.
- `reset_p` in 1: reset; synchronous and active-high.
- `btn` in 1: speed button; single-cycle pulse from the debouncer/edge detector.
- `timeout` in 1: fan timer timeout; level or pulse, high means force off.
- `duty` out 8: current PWM duty command (registered).
- `level` out 2: selected speed; 0 = off, 1 = low, 2 = mid, 3 = high.
- `ramping` out 1: high while `duty` ≠ target.

## Operation
- **Level FSM.** States OFF → LOW → MID → HIGH → OFF, advanced on each `btn` pulse.
- **Timeout.** `timeout` high sends the FSM to OFF from any state. While `timeout` stays high, the FSM holds OFF and `btn` is ignored.
- **Simultaneous events.** `btn` and `timeout` high in the same cycle: `timeout` wins (OFF).
- **Target duty.** OFF → 0, LOW → `DUTY_LOW`, MID → `DUTY_MID`, HIGH → `DUTY_HIGH`.
- **Entering OFF.** `duty` goes to 0 immediately (next cycle), with no ramp. The fan timer treats duty = 0 as power off and clears itself.
- **Ramping between levels.** Both ramp-up (OFF→LOW, LOW→MID, MID→HIGH) and any ramp-down between nonzero targets move `duty` 1 LSB toward the target on each step strobe.
- **Reaching the target.** `duty` stops exactly at the target, with no overshoot.
- **Arithmetic.** 8-bit unsigned. An increment at 255 or a decrement at 0 never occurs (guarded by compare to target).
- **Step strobe.** The ms tick counter counts 0..`RAMP_MS`-1 and asserts the step strobe on the ms tick where it equals `RAMP_MS`-1, then wraps to 0. The counter is free-running, not restarted on a level change.
- **Target change mid-ramp.** Ramping continues from the current `duty` toward the new target, with no jump.
- **`ramping`.** Combinational compare `duty != target`, driven from registered values.

## Timing
- **Reset values.** `duty` = 0, `level` = 0, `ramping` = 0. The ms prescaler and step counter clear to 0.
- **Reset mid-ramp.** All of the above apply on the next edge.
- **`btn` latency.** A `btn` pulse in cycle N gives the new `level` at cycle N+1.
- **First duty step.** Occurs at the first step strobe after N+1, i.e. up to `RAMP_MS`×`CLK_PER_MS` cycles later.
- **`timeout` latency.** `timeout` high in cycle N gives `level` = 0 and `duty` = 0 at cycle N+1.
- **Full ramp time.** OFF→HIGH takes 255 steps, about 255×`RAMP_MS` ms (≈1.02 s at defaults).
- **`btn` during a ramp.** Accepted every cycle; no lockout.

## Structure
- **Shared package `fan_pkg`.** Holds the level encodings (`LVL_OFF`=0, `LVL_LOW`=1, `LVL_MID`=2, `LVL_HIGH`=3) and the default duty constants. Fan timer, LED driver and PWM share these.
- **Sub-module.** One instance of the codebase `clock_div` (parameter `CLK_PER_MS`) produces the 1 ms `div_edge` strobe.
- **Inside this module.** FSM, step counter and duty register.

## Test plan
Bench parameters: `CLK_PER_MS`=10, `RAMP_MS`=2.
- **Reset.** `reset_p` high for 3 cycles → `duty`=0, `level`=0, `ramping`=0; hold for 500 cycles → values unchanged.
- **Single button press.** One `btn` pulse → `level`=1 next cycle; `duty` rises by 1 every 20 cycles and reaches 64 after about 1280 cycles; `ramping` then falls to 0.
- **Full cycle.** Four `btn` pulses, each after the ramp settles → `level` goes 1,2,3,0; `duty` settles at 64, 128, 255, then 0 the cycle after the 4th press.
- **Timeout.** At `level`=3 with `duty`=200 mid-ramp, assert `timeout` for 5 cycles while pulsing `btn` → `level`=0 and `duty`=0 from the next cycle; `btn` is ignored while `timeout` is high.
- **Simultaneous events and reversal.** `btn` and `timeout` in the same cycle at `level`=1 → `level`=0. Separately, a `btn` press at `duty`=100 while ramping to 128 raises the target to 255, and the ramp continues 101, 102, …
- **Reset mid-ramp.** Assert `reset_p` at `duty`=37 → `duty`=0 and `level`=0 on the next edge; the step counter restarts from 0.
